// File: rtl/logic_noise_sequencer_if.sv
// Control/config and audio bundle for logic_noise_sequencer.
interface logic_noise_sequencer_if #(
  parameter int NUM_VOICES = 8,
  parameter int STEP_W     = 3,
  parameter int DATA_W     = 16
);
  logic [NUM_VOICES-1:0] btn;
  logic                  cfg_we;
  logic                  cfg_sel;
  logic [3:0]            cfg_addr;
  logic [DATA_W-1:0]     cfg_data;
  logic [1:0]            mix_mode;
  logic [STEP_W-1:0]     step;
  logic                  step_tick;
  logic [NUM_VOICES-1:0] voice_out;
  logic                  audio_out;

  modport master (
    output btn, cfg_we, cfg_sel, cfg_addr,
    output cfg_data, mix_mode,
    input  step, step_tick, voice_out, audio_out
  );

  modport slave (
    input  btn, cfg_we, cfg_sel, cfg_addr,
    input  cfg_data, mix_mode,
    output step, step_tick, voice_out, audio_out
  );
endinterface

// File: rtl/logic_noise_sequencer.sv
// N-voice square-wave sequencer with step gating and mixing.
// Define MIX_PWM_EN to turn mix mode 11 into a popcount PWM.
module logic_noise_sequencer #(
  parameter int NUM_VOICES = 8,
  parameter int PERIOD_W   = 16,
  parameter int STEPS      = 8,
  parameter int TEMPO_DIV  = 524288
) (
  input logic                      clk,
  input logic                      rst_n,
  logic_noise_sequencer_if.slave   bus
);
  localparam int STEP_W = $clog2(STEPS);
  localparam int TW     = $clog2(TEMPO_DIV);

  logic [NUM_VOICES-1:0] sq;
  logic [NUM_VOICES-1:0] active;
  logic [NUM_VOICES-1:0] gate;
  logic [TW-1:0]         tcnt;
  logic [STEP_W-1:0]     step_q;
  logic                  mix;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [STEPS-1:0]    pattern;
    logic                sq_q;
    logic                hit;

    // out-of-range addresses never match any voice
    assign hit = bus.cfg_we && (bus.cfg_addr == 4'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        period  <= '0;
        pattern <= '0;
        cnt     <= '0;
        sq_q    <= 1'b0;
      end else begin
        if (hit && !bus.cfg_sel)
          period <= bus.cfg_data[PERIOD_W-1:0];
        if (hit && bus.cfg_sel)
          pattern <= bus.cfg_data[STEPS-1:0];
        if (period == '0) begin
          cnt  <= '0;
          sq_q <= 1'b0;
        end else if (cnt >= period - PERIOD_W'(1)) begin
          cnt  <= '0;
          sq_q <= ~sq_q;
        end else begin
          cnt <= cnt + PERIOD_W'(1);
        end
      end
    end

    assign sq[i]     = sq_q;
    assign active[i] = |period;
    assign gate[i]   = pattern[step_q] | bus.btn[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt          <= '0;
      step_q        <= '0;
      bus.step_tick <= 1'b0;
    end else if (tcnt == TW'(TEMPO_DIV - 1)) begin
      tcnt          <= '0;
      bus.step_tick <= 1'b1;
      step_q        <= (step_q == STEP_W'(STEPS - 1))
                     ? '0 : step_q + STEP_W'(1);
    end else begin
      tcnt          <= tcnt + TW'(1);
      bus.step_tick <= 1'b0;
    end
  end

  assign bus.step = step_q;

`ifdef MIX_PWM_EN
  localparam int CW = $clog2(NUM_VOICES + 1);

  logic [CW-1:0] pcnt;
  logic [CW-1:0] sum;
  logic          pwm_bit;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      sum = sum + CW'(bus.voice_out[i]);
  end

  assign pwm_bit = pcnt < sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcnt <= '0;
    else if (pcnt == CW'(NUM_VOICES - 1))
      pcnt <= '0;
    else
      pcnt <= pcnt + CW'(1);
  end
`endif

  // AND only considers voices that have a nonzero period
  always_comb begin
    mix = 1'b0;
    unique case (bus.mix_mode)
      2'b00: mix = |bus.voice_out;
      2'b01: mix = ^bus.voice_out;
      2'b10: mix = (|active) & (&(bus.voice_out | ~active));
`ifdef MIX_PWM_EN
      2'b11: mix = pwm_bit;
`else
      2'b11: mix = 1'b0;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.voice_out <= '0;
      bus.audio_out <= 1'b0;
    end else begin
      bus.voice_out <= sq & gate;
      bus.audio_out <= mix;
    end
  end
endmodule

// File: tb/tb_logic_noise_sequencer.sv
// Bench for logic_noise_sequencer: cycle model feeding a
// scoreboard, table of mix scenarios, hand-written corner cases.
module tb_logic_noise_sequencer;
  localparam int NV = 4;
  localparam int PW = 8;
  localparam int ST = 8;
  localparam int TD = 4;
  localparam int SW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_noise_sequencer_if #(
    .NUM_VOICES(NV), .STEP_W(SW), .DATA_W(DW)
  ) bus ();

  logic_noise_sequencer #(
    .NUM_VOICES(NV), .PERIOD_W(PW),
    .STEPS(ST), .TEMPO_DIV(TD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [NV-1:0] vo;
    logic          au;
    logic [SW-1:0] st;
    logic          tk;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    int         p0;
    int         p1;
    int         cycles;
    bit         quiet;
  } vec_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [PW-1:0] m_per[NV];
  logic [ST-1:0] m_pat[NV];
  int            m_cnt[NV];
  logic [NV-1:0] m_sq;
  logic [NV-1:0] m_vo;
  int            m_tcnt;
  int            m_step;
  int            prev_step;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_per[i] = '0;
      m_pat[i] = '0;
      m_cnt[i] = 0;
    end
    m_sq   = '0;
    m_vo   = '0;
    m_tcnt = 0;
    m_step = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    exp_t          e;
    logic [NV-1:0] act;
    int            a;
    for (int i = 0; i < NV; i++) begin
      e.vo[i] = m_sq[i] & (m_pat[i][m_step] | bus.btn[i]);
      act[i]  = (m_per[i] != 0);
    end
    case (bus.mix_mode)
      2'd0:    e.au = |m_vo;
      2'd1:    e.au = ^m_vo;
      2'd2:    e.au = (act != 0) && ((m_vo & act) == act);
      default: e.au = 1'b0;
    endcase
    for (int i = 0; i < NV; i++) begin
      if (m_per[i] == 0) begin
        m_cnt[i] = 0;
        m_sq[i]  = 1'b0;
      end else if (m_cnt[i] + 1 >= int'(m_per[i])) begin
        m_cnt[i] = 0;
        m_sq[i]  = ~m_sq[i];
      end else begin
        m_cnt[i]++;
      end
    end
    e.tk = (m_tcnt == TD - 1);
    if (e.tk) begin
      m_tcnt = 0;
      m_step = (m_step + 1) % ST;
    end else begin
      m_tcnt++;
    end
    e.st = SW'(m_step);
    a = int'(bus.cfg_addr);
    if (bus.cfg_we && a < NV) begin
      if (bus.cfg_sel) m_pat[a] = bus.cfg_data[ST-1:0];
      else             m_per[a] = bus.cfg_data[PW-1:0];
    end
    m_vo = e.vo;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    prev_step = int'(bus.step);
    model_step();
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("voice_out", int'(bus.voice_out), int'(e.vo));
      chk("audio_out", int'(bus.audio_out), int'(e.au));
      chk("step", int'(bus.step), int'(e.st));
      chk("step_tick", int'(bus.step_tick), int'(e.tk));
    end
  endtask

  task automatic cfg_write(bit sel, int addr, int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = DW'(data);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("rst_voice_out", int'(bus.voice_out), 0);
    chk("rst_audio_out", int'(bus.audio_out), 0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_step_tick", int'(bus.step_tick), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vt[6];

  initial begin
    int       run, edges, last, exp_st, ntk, ones;
    logic     pb;
    logic [7:0] mask;

    vt[0] = '{2'b00, 2, 4, 40, 1'b0};
    vt[1] = '{2'b01, 2, 4, 40, 1'b0};
    vt[2] = '{2'b10, 2, 4, 40, 1'b0};
    vt[3] = '{2'b10, 2, 0, 40, 1'b0};
    vt[4] = '{2'b10, 0, 0, 40, 1'b1};
    vt[5] = '{2'b11, 2, 4, 40, 1'b1};

    bus.btn      = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.mix_mode = 2'b00;
    do_reset();

    // pitch: period 3 gives 3 high / 3 low
    cfg_write(1, 0, 8'hFF);
    cfg_write(0, 0, 3);
    run = 0;
    edges = 0;
    pb = bus.voice_out[0];
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.voice_out[0] !== pb) begin
        if (edges > 0) chk("t2_half_period", run, 3);
        edges++;
        run = 1;
        pb = bus.voice_out[0];
      end else begin
        run++;
      end
    end
    chk("t2_edges_seen", int'(edges >= 10), 1);

    // tempo: tick every TD cycles, step wraps 7 -> 0
    do_reset();
    last = -1;
    exp_st = 0;
    ntk = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.step_tick) begin
        exp_st = (exp_st + 1) % ST;
        chk("t3_step", int'(bus.step), exp_st);
        if (last >= 0) chk("t3_tick_gap", c - last, TD);
        last = c;
        ntk++;
      end
    end
    chk("t3_tick_count", ntk, 10);

    // gate: pattern 0000_0101, then btn forces all steps
    do_reset();
    cfg_write(1, 1, 8'b0000_0101);
    cfg_write(0, 1, 2);
    mask = '0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (bus.voice_out[1]) mask[prev_step] = 1'b1;
    end
    chk("t4_pattern_steps", int'(mask), 8'b0000_0101);
    bus.btn[1] = 1'b1;
    tick();
    mask = '0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (bus.voice_out[1]) mask[prev_step] = 1'b1;
    end
    chk("t4_btn_steps", int'(mask), 8'hFF);
    bus.btn = '0;

    // mix scenarios
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.mix_mode = vt[v].mode;
      cfg_write(1, 0, 8'hFF);
      cfg_write(1, 1, 8'hFF);
      cfg_write(0, 0, vt[v].p0);
      cfg_write(0, 1, vt[v].p1);
      ones = 0;
      for (int c = 0; c < vt[v].cycles; c++) begin
        tick();
        ones += int'(bus.audio_out);
      end
      chk($sformatf("t5_quiet_vec%0d", v), int'(ones == 0),
          int'(vt[v].quiet));
    end

    // writes to addresses beyond NUM_VOICES are ignored
    do_reset();
    bus.mix_mode = 2'b10;
    bus.btn = '1;
    cfg_write(0, 15, 1);
    cfg_write(0, 4, 1);
    cfg_write(1, 15, 8'hFF);
    ones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      ones += int'(bus.voice_out != 0) + int'(bus.audio_out);
    end
    chk("t5_addr_oob_ignored", ones, 0);
    bus.btn = '0;

    // pattern write lands on the same edge as step_tick
    do_reset();
    bus.mix_mode = 2'b00;
    cfg_write(0, 2, 1);
    tick();
    tick();
    cfg_write(1, 2, 8'b0000_0010);
    chk("simul_step_tick", int'(bus.step_tick), 1);
    chk("simul_step", int'(bus.step), 1);
    ones = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      ones += int'(bus.voice_out[2]);
    end
    chk("simul_new_gate", int'(ones > 0), 1);

    // reset mid-note clears periods and patterns
    bus.btn = '1;
    cfg_write(0, 0, 1);
    for (int c = 0; c < 5; c++) tick();
    do_reset();
    ones = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      ones += int'(bus.voice_out != 0);
    end
    chk("t1_periods_cleared", ones, 0);
    bus.btn = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
